// File: rtl/scene_pkg.sv
// -----------------------------------------------------------------------------
// scene_pkg
// Shared definitions for the scene command path.
//   - Default sizes for the sphere table and the error counter.
//   - Bit positions of the fields in a 64-bit host command word.
//   - Opcode enumeration, scheduler state enumeration and the sphere record.
// -----------------------------------------------------------------------------
package scene_pkg;

    localparam int DEF_MAX_SPHERES = 16;
    localparam int DEF_IDX_W       = 4;
    localparam int DEF_COORD_W     = 14;
    localparam int DEF_ERR_W       = 8;

    // Command word layout: [63:60] opcode, [59:56] index, [55:0] payload
    localparam int CMD_W   = 64;
    localparam int OP_MSB  = 63;
    localparam int OP_LSB  = 60;
    localparam int IDX_MSB = 59;
    localparam int IDX_LSB = 56;
    localparam int PAY_MSB = 55;
    localparam int PAY_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP          = 4'h0,
        OP_WRITE_SPHERE = 4'h1,
        OP_SET_COUNT    = 4'h2,
        OP_COMMIT       = 4'hF
    } opcode_t;

    typedef enum logic {
        ST_ACCEPT      = 1'b0,
        ST_COMMIT_WAIT = 1'b1
    } sched_state_t;

    // Field order gives x=[55:42], y=[41:28], z=[27:14], r=[13:0]
    typedef struct packed {
        logic [DEF_COORD_W-1:0] x;
        logic [DEF_COORD_W-1:0] y;
        logic [DEF_COORD_W-1:0] z;
        logic [DEF_COORD_W-1:0] r;
    } sphere_t;

endpackage

// File: rtl/scene_bank_regfile.sv
// -----------------------------------------------------------------------------
// scene_bank_regfile
// Double-buffered sphere table held in flops so both banks clear on reset.
// Writes always land in the shadow bank (the one not selected by
// active_bank); the single read port returns the active-bank record one
// cycle after rd_idx is presented.
// Ports:
//   clk, rst_    clock, asynchronous active-low reset
//   active_bank  bank currently visible to the reader
//   wr_en/wr_idx/wr_data  shadow-bank write port
//   rd_idx/rd_data        registered active-bank read port
// -----------------------------------------------------------------------------
module scene_bank_regfile #(
    parameter int NUM_SLOTS = 16,
    parameter int IDX_W     = 4,
    parameter int REC_W     = 56
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             active_bank,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [REC_W-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [REC_W-1:0] rd_data
);

    logic [REC_W-1:0] bank0_rec [NUM_SLOTS];
    logic [REC_W-1:0] bank1_rec [NUM_SLOTS];
    logic [REC_W-1:0] rd_data_reg;

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        logic [REC_W-1:0] b0_reg;
        logic [REC_W-1:0] b1_reg;
        logic             hit;

        assign hit = wr_en && (wr_idx == IDX_W'(gi));

        always_ff @(posedge clk or negedge rst_) begin
            if (!rst_) begin
                b0_reg <= '0;
                b1_reg <= '0;
            end else if (hit) begin
                // Shadow bank is the one not being read
                if (active_bank) begin
                    b0_reg <= wr_data;
                end else begin
                    b1_reg <= wr_data;
                end
            end
        end

        assign bank0_rec[gi] = b0_reg;
        assign bank1_rec[gi] = b1_reg;
    end

    // Uses the pre-edge bank select, so a read issued on the swap edge
    // still returns the old bank.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= active_bank ? bank1_rec[rd_idx] : bank0_rec[rd_idx];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/scene_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// scene_cmd_scheduler
// Decodes host command words into writes of a double-buffered sphere table
// and swaps banks only on a frame boundary after a COMMIT.
// Ports:
//   clk, rst_       clock, asynchronous active-low reset
//   i_Acc_DV        strobe qualifying i_Acc_Bytes
//   i_Acc_Bytes     command word {opcode, index, payload}
//   i_frame_start   vertical-blank pulse; the only point a swap may happen
//   i_rd_idx        raytracer read index
//   o_rd_sphere     active-bank record, 1-cycle latency
//   o_sphere_count  valid spheres in the active bank
//   o_bank          active bank select
//   o_busy          commit pending (host interrupt)
//   o_err_cnt       saturating count of rejected words
// -----------------------------------------------------------------------------
module scene_cmd_scheduler
    import scene_pkg::*;
#(
    parameter int MAX_SPHERES = DEF_MAX_SPHERES,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int COORD_W     = DEF_COORD_W,
    parameter int ERR_W       = DEF_ERR_W
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 i_Acc_DV,
    input  logic [CMD_W-1:0]     i_Acc_Bytes,
    input  logic                 i_frame_start,
    input  logic [IDX_W-1:0]     i_rd_idx,
    output logic [4*COORD_W-1:0] o_rd_sphere,
    output logic [IDX_W:0]       o_sphere_count,
    output logic                 o_bank,
    output logic                 o_busy,
    output logic [ERR_W-1:0]     o_err_cnt
);

    sched_state_t state_reg, state_next;

    logic [CMD_W-1:0] cmd_reg;
    logic             cmd_vld_reg;
    logic             cmd_in_wait_reg;
    logic [IDX_W:0]   shadow_count_reg;
    logic [IDX_W:0]   active_count_reg;
    logic             bank_reg;
    logic [ERR_W-1:0] err_cnt_reg;

    logic [3:0]       cmd_op;
    logic [3:0]       cmd_idx;
    logic [IDX_W:0]   cnt_raw;
    sphere_t          wr_rec;
    logic             in_wait;
    logic             do_write;
    logic             do_set_count;
    logic             do_commit;
    logic             reject;
    logic             swap;

    assign cmd_op  = cmd_reg[OP_MSB:OP_LSB];
    assign cmd_idx = cmd_reg[IDX_MSB:IDX_LSB];
    assign cnt_raw = cmd_reg[PAY_LSB +: IDX_W+1];
    assign wr_rec  = cmd_reg[PAY_MSB:PAY_LSB];

    // A word counts as received during the commit wait if it arrived while
    // waiting (including on the swap edge itself) or is decoded while waiting.
    assign in_wait = cmd_in_wait_reg || (state_reg == ST_COMMIT_WAIT);
    assign swap    = (state_reg == ST_COMMIT_WAIT) && i_frame_start;

    // Command decode
    always_comb begin
        do_write     = 1'b0;
        do_set_count = 1'b0;
        do_commit    = 1'b0;
        reject       = 1'b0;
        if (cmd_vld_reg) begin
            if (in_wait) begin
                reject = (cmd_op != OP_NOP);
            end else begin
                case (cmd_op)
                    OP_NOP: ;
                    OP_WRITE_SPHERE: begin
                        if (32'(cmd_idx) >= 32'(MAX_SPHERES)) begin
                            reject = 1'b1;
                        end else begin
                            do_write = 1'b1;
                        end
                    end
                    OP_SET_COUNT: begin
                        do_set_count = 1'b1;
                        reject       = (cnt_raw > (IDX_W+1)'(MAX_SPHERES));
                    end
                    OP_COMMIT: do_commit = 1'b1;
                    default:   reject    = 1'b1;
                endcase
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_reg <= ST_ACCEPT;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state. A frame_start coincident with COMMIT decode is ignored
    // because the FSM is still in ACCEPT on that edge.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ACCEPT:      if (do_commit)     state_next = ST_COMMIT_WAIT;
            ST_COMMIT_WAIT: if (i_frame_start) state_next = ST_ACCEPT;
            default:        state_next = ST_ACCEPT;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_busy = (state_reg == ST_COMMIT_WAIT);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cmd_reg          <= '0;
            cmd_vld_reg      <= 1'b0;
            cmd_in_wait_reg  <= 1'b0;
            shadow_count_reg <= '0;
            active_count_reg <= '0;
            bank_reg         <= 1'b0;
            err_cnt_reg      <= '0;
        end else begin
            cmd_vld_reg <= i_Acc_DV;
            if (i_Acc_DV) begin
                cmd_reg         <= i_Acc_Bytes;
                cmd_in_wait_reg <= (state_reg == ST_COMMIT_WAIT);
            end
            if (do_set_count) begin
                shadow_count_reg <= reject ? (IDX_W+1)'(MAX_SPHERES) : cnt_raw;
            end
            if (swap) begin
                bank_reg         <= ~bank_reg;
                active_count_reg <= shadow_count_reg;
            end
            if (reject && (err_cnt_reg != {ERR_W{1'b1}})) begin
                err_cnt_reg <= err_cnt_reg + ERR_W'(1);
            end
        end
    end

    scene_bank_regfile #(
        .NUM_SLOTS (MAX_SPHERES),
        .IDX_W     (IDX_W),
        .REC_W     (4*COORD_W)
    ) u_bank_regfile (
        .clk         (clk),
        .rst_        (rst_),
        .active_bank (bank_reg),
        .wr_en       (do_write),
        .wr_idx      (cmd_idx[IDX_W-1:0]),
        .wr_data     (wr_rec),
        .rd_idx      (i_rd_idx),
        .rd_data     (o_rd_sphere)
    );

    assign o_sphere_count = active_count_reg;
    assign o_bank         = bank_reg;
    assign o_err_cnt      = err_cnt_reg;

endmodule

// File: tb/tb_scene_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_scene_cmd_scheduler
// Directed testbench for scene_cmd_scheduler: command decode, bank swap
// timing, rejection/saturation of the error counter, async reset.
// -----------------------------------------------------------------------------
module tb_scene_cmd_scheduler;

    logic        clk;
    logic        rst_;
    logic        i_Acc_DV;
    logic [63:0] i_Acc_Bytes;
    logic        i_frame_start;
    logic [3:0]  i_rd_idx;
    logic [55:0] o_rd_sphere;
    logic [4:0]  o_sphere_count;
    logic        o_bank;
    logic        o_busy;
    logic [7:0]  o_err_cnt;

    int checks   = 0;
    int failures = 0;

    localparam logic [55:0] REC_A = 56'h0001_0002_0003_0004;
    localparam logic [55:0] REC_B = 56'h00DE_AD00_BEEF_42;

    scene_cmd_scheduler dut (
        .clk            (clk),
        .rst_           (rst_),
        .i_Acc_DV       (i_Acc_DV),
        .i_Acc_Bytes    (i_Acc_Bytes),
        .i_frame_start  (i_frame_start),
        .i_rd_idx       (i_rd_idx),
        .o_rd_sphere    (o_rd_sphere),
        .o_sphere_count (o_sphere_count),
        .o_bank         (o_bank),
        .o_busy         (o_busy),
        .o_err_cnt      (o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clocks; returns 1 time unit after the last rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one word for one cycle; it is latched on that edge and
    // decoded on the next one.
    task automatic send_word(input logic [3:0] op, input logic [3:0] idx,
                             input logic [55:0] pl);
        i_Acc_Bytes = {op, idx, pl};
        i_Acc_DV    = 1'b1;
        $display("TXN t=%0t op=%h idx=%0d payload=%h", $time, op, idx, pl);
        tick(1);
        i_Acc_DV    = 1'b0;
    endtask

    task automatic pulse_frame();
        i_frame_start = 1'b1;
        tick(1);
        i_frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        tick(2);
        if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        checks++;
        if (o_bank !== 1'b0) begin failures++; $display("FAIL reset_bank: got %b expected 0", o_bank); end
        checks++;
        if (o_sphere_count !== 5'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", o_sphere_count); end
        checks++;
        if (o_err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err: got %0d expected 0", o_err_cnt); end
        checks++;
        if (o_rd_sphere !== 56'd0) begin failures++; $display("FAIL reset_rd: got %h expected 0", o_rd_sphere); end
        checks++;
        @(negedge clk);
        rst_ = 1'b1;
        tick(1);
    endtask

    task automatic test_basic_commit();
        send_word(4'h1, 4'd2, REC_A);
        tick(1);
        send_word(4'h2, 4'd0, 56'd3);
        tick(1);
        send_word(4'hF, 4'd0, 56'd0);
        tick(1);
        if (o_busy !== 1'b1) begin failures++; $display("FAIL basic_busy_set: got %b expected 1", o_busy); end
        checks++;
        if (o_bank !== 1'b0) begin failures++; $display("FAIL basic_bank_pre: got %b expected 0", o_bank); end
        checks++;
        pulse_frame();
        if (o_bank !== 1'b1) begin failures++; $display("FAIL basic_bank_swap: got %b expected 1", o_bank); end
        checks++;
        if (o_sphere_count !== 5'd3) begin failures++; $display("FAIL basic_count: got %0d expected 3", o_sphere_count); end
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_clr: got %b expected 0", o_busy); end
        checks++;
        i_rd_idx = 4'd2;
        tick(1);
        if (o_rd_sphere !== REC_A) begin failures++; $display("FAIL basic_read_idx2: got %h expected %h", o_rd_sphere, REC_A); end
        checks++;
    endtask

    task automatic test_commit_reject();
        send_word(4'hF, 4'd0, 56'd0);
        tick(1);
        send_word(4'h1, 4'd0, 56'hAB);
        tick(1);
        if (o_err_cnt !== 8'd1) begin failures++; $display("FAIL pend_write_err: got %0d expected 1", o_err_cnt); end
        checks++;
        send_word(4'hF, 4'd0, 56'd0);
        tick(1);
        if (o_err_cnt !== 8'd2) begin failures++; $display("FAIL pend_commit_err: got %0d expected 2", o_err_cnt); end
        checks++;
        if (o_busy !== 1'b1) begin failures++; $display("FAIL pend_busy: got %b expected 1", o_busy); end
        checks++;
        pulse_frame();
        if (o_bank !== 1'b0) begin failures++; $display("FAIL pend_swap_bank: got %b expected 0", o_bank); end
        checks++;
        i_rd_idx = 4'd0;
        tick(1);
        if (o_rd_sphere !== 56'd0) begin failures++; $display("FAIL pend_idx0_kept: got %h expected 0", o_rd_sphere); end
        checks++;
        tick(2);
        pulse_frame();
        if (o_bank !== 1'b0) begin failures++; $display("FAIL pend_single_swap: got %b expected 0", o_bank); end
        checks++;
    endtask

    task automatic test_coincident_frame();
        i_Acc_Bytes   = {4'hF, 4'd0, 56'd0};
        i_Acc_DV      = 1'b1;
        $display("TXN t=%0t op=f idx=0 payload=0 (frame on decode edge)", $time);
        tick(1);
        i_Acc_DV      = 1'b0;
        i_frame_start = 1'b1;
        tick(1);
        i_frame_start = 1'b0;
        if (o_busy !== 1'b1) begin failures++; $display("FAIL coinc_busy: got %b expected 1", o_busy); end
        checks++;
        if (o_bank !== 1'b0) begin failures++; $display("FAIL coinc_no_swap: got %b expected 0", o_bank); end
        checks++;
        tick(2);
        pulse_frame();
        if (o_bank !== 1'b1) begin failures++; $display("FAIL coinc_late_swap: got %b expected 1", o_bank); end
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL coinc_busy_clr: got %b expected 0", o_busy); end
        checks++;
    endtask

    task automatic test_dv_on_swap_edge();
        send_word(4'hF, 4'd0, 56'd0);
        tick(1);
        i_Acc_Bytes   = {4'h1, 4'd5, 56'h55};
        i_Acc_DV      = 1'b1;
        i_frame_start = 1'b1;
        $display("TXN t=%0t op=1 idx=5 payload=55 (on swap edge)", $time);
        tick(1);
        i_Acc_DV      = 1'b0;
        i_frame_start = 1'b0;
        tick(1);
        if (o_err_cnt !== 8'd3) begin failures++; $display("FAIL swapedge_err: got %0d expected 3", o_err_cnt); end
        checks++;
        if (o_bank !== 1'b0) begin failures++; $display("FAIL swapedge_bank: got %b expected 0", o_bank); end
        checks++;
    endtask

    task automatic test_clamp_and_bad();
        send_word(4'h2, 4'd0, 56'd20);
        tick(1);
        if (o_err_cnt !== 8'd4) begin failures++; $display("FAIL clamp_err: got %0d expected 4", o_err_cnt); end
        checks++;
        send_word(4'hF, 4'd0, 56'd0);
        tick(1);
        pulse_frame();
        if (o_sphere_count !== 5'd16) begin failures++; $display("FAIL clamp_count: got %0d expected 16", o_sphere_count); end
        checks++;
        send_word(4'h7, 4'd3, 56'h1234);
        tick(1);
        if (o_err_cnt !== 8'd5) begin failures++; $display("FAIL badop_err: got %0d expected 5", o_err_cnt); end
        checks++;
        if (o_bank !== 1'b1 || o_busy !== 1'b0) begin failures++; $display("FAIL badop_state: got bank=%b busy=%b expected bank=1 busy=0", o_bank, o_busy); end
        checks++;
        i_Acc_Bytes = {4'h7, 4'd0, 56'd0};
        i_Acc_DV    = 1'b1;
        $display("TXN t=%0t op=7 x300 back-to-back", $time);
        tick(300);
        i_Acc_DV    = 1'b0;
        tick(2);
        if (o_err_cnt !== 8'd255) begin failures++; $display("FAIL err_saturate: got %0d expected 255", o_err_cnt); end
        checks++;
    endtask

    task automatic test_stream_reads();
        send_word(4'h1, 4'd2, REC_B);
        tick(1);
        send_word(4'hF, 4'd0, 56'd0);
        i_rd_idx = 4'd2;
        tick(1);
        if (o_rd_sphere !== REC_A) begin failures++; $display("FAIL stream_pre: got %h expected %h", o_rd_sphere, REC_A); end
        checks++;
        pulse_frame();
        if (o_rd_sphere !== REC_A) begin failures++; $display("FAIL stream_swap_edge: got %h expected %h", o_rd_sphere, REC_A); end
        checks++;
        tick(1);
        if (o_rd_sphere !== REC_B) begin failures++; $display("FAIL stream_after: got %h expected %h", o_rd_sphere, REC_B); end
        checks++;
        if (o_bank !== 1'b0) begin failures++; $display("FAIL stream_bank: got %b expected 0", o_bank); end
        checks++;
    endtask

    task automatic test_reset_mid_commit();
        send_word(4'hF, 4'd0, 56'd0);
        tick(1);
        if (o_busy !== 1'b1) begin failures++; $display("FAIL rstmid_pre_busy: got %b expected 1", o_busy); end
        checks++;
        #2;
        rst_ = 1'b0;
        #1;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", o_busy); end
        checks++;
        if (o_bank !== 1'b0) begin failures++; $display("FAIL rstmid_bank: got %b expected 0", o_bank); end
        checks++;
        if (o_sphere_count !== 5'd0) begin failures++; $display("FAIL rstmid_count: got %0d expected 0", o_sphere_count); end
        checks++;
        @(negedge clk);
        rst_ = 1'b1;
        tick(1);
        for (int i = 0; i < 16; i++) begin
            i_rd_idx = 4'(i);
            tick(1);
            if (o_rd_sphere !== 56'd0) begin failures++; $display("FAIL rstmid_read%0d: got %h expected 0", i, o_rd_sphere); end
            checks++;
        end
        pulse_frame();
        if (o_bank !== 1'b0) begin failures++; $display("FAIL rstmid_no_swap: got %b expected 0", o_bank); end
        checks++;
    endtask

    initial begin
        rst_          = 1'b0;
        i_Acc_DV      = 1'b0;
        i_Acc_Bytes   = '0;
        i_frame_start = 1'b0;
        i_rd_idx      = '0;
        test_reset();
        test_basic_commit();
        test_commit_reject();
        test_coincident_frame();
        test_dv_on_swap_edge();
        test_clamp_and_bad();
        test_stream_reads();
        test_reset_mid_commit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
